button_bank_monitor: RTL and testbench

//  Multi-channel successor to the single button monitor in the digital-lock datapath.
//  - Synchronises NUM_BUTTONS raw button inputs and debounces each one.
//  - Emits per-channel press, release and long-press pulses.
//  - Emits an encoded key event that the lock FSM consumes directly.

---
 rtl/button_bank_monitor.sv | 71 +++++++
 tb/tb_button_bank_monitor.sv | 127 ++++++++++++
 2 files changed

// File: rtl/button_bank_monitor.sv
// button_bank_monitor: synchronise, debounce and encode a bank of push buttons with press/release/hold pulses
module button_bank_monitor #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 0,
  parameter int CODE_WIDTH      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttonPress,
  output logic [NUM_BUTTONS-1:0] buttonState,
  output logic [NUM_BUTTONS-1:0] buttonEdge,
  output logic [NUM_BUTTONS-1:0] buttonRelease,
  output logic [NUM_BUTTONS-1:0] buttonHold,
  output logic                   keyValid,
  output logic [CODE_WIDTH-1:0]  keyCode,
  output logic                   keyMulti
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NUM_BUTTONS-1:0] sync1, sync2, accept, edge_next, rel_next;
  logic [NUM_BUTTONS-1:0][DW-1:0] dcnt;
  logic [CODE_WIDTH-1:0] code_next;
  always_comb begin
    accept = '0;
    code_next = '0;
    for (int c = 0; c < NUM_BUTTONS; c++)
      accept[c] = (sync2[c] != buttonState[c]) && (dcnt[c] == DW'(DEBOUNCE_CYCLES - 1));
    for (int c = NUM_BUTTONS - 1; c >= 0; c--)
      code_next = edge_next[c] ? CODE_WIDTH'(c) : code_next;
  end
  assign edge_next = accept & sync2;
  assign rel_next  = accept & ~sync2;
  always_ff @(posedge clock)
    for (int c = 0; c < NUM_BUTTONS; c++)
      dcnt[c] <= (reset || sync2[c] == buttonState[c] || accept[c]) ? '0 : dcnt[c] + DW'(1);
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      buttonState   <= '0;
      buttonEdge    <= '0;
      buttonRelease <= '0;
      keyValid      <= 1'b0;
      keyCode       <= '0;
      keyMulti      <= 1'b0;
    end else begin
      sync1         <= buttonPress;
      sync2         <= sync1;
      buttonState   <= buttonState ^ accept;
      buttonEdge    <= edge_next;
      buttonRelease <= rel_next;
      keyValid      <= |edge_next;
      keyCode       <= code_next;
      keyMulti      <= |(edge_next & (edge_next - NUM_BUTTONS'(1)));
    end
  end
  generate
    if (HOLD_CYCLES == 0) begin : g_nohold
      assign buttonHold = '0;
    end else begin : g_hold
      localparam int HW = $clog2(HOLD_CYCLES + 1);
      logic [NUM_BUTTONS-1:0][HW-1:0] hcnt;
      always_ff @(posedge clock)
        for (int c = 0; c < NUM_BUTTONS; c++) begin
          hcnt[c]       <= (reset || !buttonState[c]) ? '0 :
                           (hcnt[c] == HW'(HOLD_CYCLES)) ? hcnt[c] : hcnt[c] + HW'(1);
          buttonHold[c] <= !reset && buttonState[c] && (hcnt[c] == HW'(HOLD_CYCLES - 1));
        end
    end
  endgenerate
endmodule

// File: tb/tb_button_bank_monitor.sv
// tb_button_bank_monitor: directed self-checking bench for button_bank_monitor
module tb_button_bank_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [3:0] state, edg, rel, hold;
  logic       kv, km;
  logic [1:0] kc;
  int n_cmp = 0;
  int n_err = 0;
  button_bank_monitor #(
    .NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16), .CODE_WIDTH(2)
  ) dut (
    .clock(clk), .reset(rst), .buttonPress(btn),
    .buttonState(state), .buttonEdge(edg), .buttonRelease(rel), .buttonHold(hold),
    .keyValid(kv), .keyCode(kc), .keyMulti(km)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] all_out();
    return {12'd0, state, edg, rel, hold, kv, kc, km};
  endfunction
  initial begin
    // reset with idle inputs: every output low during and after
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_all", all_out(), 32'd0);
    end
    rst = 1'b0;
    tick(2);
    check("post_rst_all", all_out(), 32'd0);
    // channel 2 press: edge on the 6th edge after the input change, hold 16 later
    btn[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("p2_pre_edge", {edg, kv}, 5'b0);
    end
    tick();
    check("p2_edge", {state, edg, kv, kc, km}, {4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0});
    tick();
    check("p2_edge_1clk", {state, edg, kv}, {4'b0100, 4'b0000, 1'b0});
    for (int i = 0; i < 14; i++) begin
      tick();
      check("p2_hold_early", hold, 4'b0000);
    end
    tick();
    check("p2_hold", hold, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("p2_hold_once", hold, 4'b0000);
    end
    // 3-sample glitch on channel 1 is never accepted
    btn[1] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 2) btn[1] = 1'b0;
      check("glitch", {state, edg, kv}, {4'b0100, 4'b0000, 1'b0});
    end
    // simultaneous press on 3 and 0
    btn[3] = 1'b1;
    btn[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("multi_pre", {edg, kv, km}, 6'b0);
    end
    tick();
    check("multi_edge", {state, edg, kv, kc, km}, {4'b1101, 4'b1001, 1'b1, 2'd0, 1'b1});
    btn[3] = 1'b0;
    btn[0] = 1'b0;
    tick();
    check("multi_1clk", {edg, kv, km, hold}, 10'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("multi_rel_pre", rel, 4'b0000);
    end
    tick();
    check("multi_rel", {state, rel}, {4'b0100, 4'b1001});
    // release channel 2, then re-press and see the hold re-arm
    btn[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r2_pre", rel, 4'b0000);
    end
    tick();
    check("r2_rel", {state, rel, edg}, {4'b0000, 4'b0100, 4'b0000});
    tick();
    check("r2_rel_1clk", rel, 4'b0000);
    btn[2] = 1'b1;
    tick(6);
    check("rp2_edge", {edg, kv, kc}, {4'b0100, 1'b1, 2'd2});
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rp2_hold_early", hold, 4'b0000);
    end
    tick();
    check("rp2_hold", hold, 4'b0100);
    btn[2] = 1'b0;
    tick(8);
    check("rp2_released", state, 4'b0000);
    // reset lands mid-debounce of channel 0 (count 2)
    btn[0] = 1'b1;
    tick(4);
    check("mid_db_no_edge", {state, edg}, 8'b0);
    rst = 1'b1;
    tick(2);
    check("mid_db_rst", all_out(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("after_rst_pre", {edg, kv}, 5'b0);
    end
    tick();
    check("after_rst_edge", {state, edg, kv, kc, km}, {4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
